// File: rtl/instr_fetch_unit.sv
// Fetch stage and IF/ID pipeline register of the 16-bit RISC core.
// Owns the PC and issues word reads over a req/ack handshake to instruction memory.
// A one-entry skid buffer absorbs a response that lands while decode is stalled.
// A redirect flushes IF/ID and the skid buffer. If a fetch is still outstanding, that
// fetch is allowed to finish at its original address and its data is then discarded.
module instr_fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [3:0]         if_id_opcode,
  output logic [PC_W-1:0]    if_id_pc_plus1
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

  state_e             state_q;
  logic [PC_W-1:0]    req_addr_q;
  logic [PC_W-1:0]    target_q;
  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc1_q;
  logic               skid_valid_q;
  logic [INSTR_W-1:0] skid_instr_q;
  logic [PC_W-1:0]    skid_pc1_q;

  logic               consume;
  logic [PC_W-1:0]    pc_plus1;

  // Decode takes IF/ID this cycle; address increment wraps modulo 2^PC_W.
  assign consume  = valid_q && !stall;
  assign pc_plus1 = req_addr_q + PC_W'(1);

  // Fetch FSM, PC, IF/ID register and skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_addr_q   <= RESET_PC;
      target_q     <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc1_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc1_q   <= '0;
    end else if (redirect_valid) begin
      // Redirect beats stall and ack: flush everything and latch the new target.
      valid_q      <= 1'b0;
      instr_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      target_q     <= redirect_pc;
      if ((state_q == StReq || state_q == StDrop) && !imem_ack) begin
        // Outstanding fetch must finish at its original address before re-targeting.
        state_q <= StDrop;
      end else begin
        state_q    <= StReq;
        req_addr_q <= redirect_pc;
      end
    end else begin
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (imem_ack) begin
            req_addr_q <= pc_plus1;
            if (!valid_q || consume) begin
              valid_q <= 1'b1;
              instr_q <= imem_rdata;
              pc1_q   <= pc_plus1;
            end else begin
              // IF/ID is full and stalled: park the response and pause fetching.
              skid_valid_q <= 1'b1;
              skid_instr_q <= imem_rdata;
              skid_pc1_q   <= pc_plus1;
              state_q      <= StHold;
            end
          end else if (consume) begin
            valid_q <= 1'b0;
            instr_q <= '0;
          end
        end
        StHold: begin
          if (consume) begin
            valid_q      <= skid_valid_q;
            instr_q      <= skid_instr_q;
            pc1_q        <= skid_pc1_q;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            state_q      <= StReq;
          end
        end
        StDrop: begin
          // The stale response is discarded; resume at the latest redirect target.
          if (imem_ack) begin
            state_q    <= StReq;
            req_addr_q <= target_q;
          end
        end
      endcase
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    imem_req       = (state_q == StReq) || (state_q == StDrop);
    imem_addr      = req_addr_q;
    if_id_valid    = valid_q;
    if_id_instr    = instr_q;
    if_id_opcode   = instr_q[INSTR_W-1 -: 4];
    if_id_pc_plus1 = pc1_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a latency-programmable memory.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [3:0]  if_id_opcode;
  logic [15:0] if_id_pc_plus1;

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int cnt    = 0;

  instr_fetch_unit #(
    .PC_W    (16),
    .INSTR_W (16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ack      (imem_ack),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_opcode  (if_id_opcode),
    .if_id_pc_plus1(if_id_pc_plus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x2123, 0x3456 at 0, 1; elsewhere addr ^ 0x5A00.
  function automatic logic [15:0] mem_data(input logic [15:0] a);
    if (a == 16'h0000) return 16'h2123;
    if (a == 16'h0001) return 16'h3456;
    return a ^ 16'h5A00;
  endfunction

  // Memory model: acks a held request 'lat' cycles after it is first seen, one-cycle ack pulse.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
  end
  always @(posedge clk) begin
    imem_ack <= 1'b0;
    if (imem_req && !imem_ack) begin
      if (cnt + 1 >= lat) begin
        imem_ack   <= 1'b1;
        imem_rdata <= mem_data(imem_addr);
        cnt        <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else if (!imem_req) begin
      cnt <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = l;
    step(); step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    checks++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++;
      $display("FAIL reset_addr got %h exp 0000", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== 16'h0000) begin errors++;
      $display("FAIL reset_instr got %h exp 0000", if_id_instr); end
    checks++; if (if_id_pc_plus1 !== 16'h0000) begin errors++;
      $display("FAIL reset_pc1 got %h exp 0000", if_id_pc_plus1); end
    checks++; if (if_id_opcode !== 4'h0) begin errors++;
      $display("FAIL reset_opcode got %h exp 0", if_id_opcode); end
  endtask

  task automatic test_fetch();
    do_reset(1);
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++;
      $display("FAIL fetch_req0 got req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
    step();
    checks++; if (if_id_valid !== 1'b0) begin errors++;
      $display("FAIL fetch_early got valid=%b exp 0", if_id_valid); end
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'h2123) begin errors++;
      $display("FAIL fetch_i0 got v=%b i=%h exp 1/2123", if_id_valid, if_id_instr); end
    checks++; if (if_id_opcode !== 4'h2 || if_id_pc_plus1 !== 16'h0001) begin errors++;
      $display("FAIL fetch_i0_meta got op=%h pc1=%h exp 2/0001", if_id_opcode, if_id_pc_plus1); end
    checks++; if (imem_addr !== 16'h0001) begin errors++;
      $display("FAIL fetch_addr1 got %h exp 0001", imem_addr); end
    step();
    checks++; if (if_id_valid !== 1'b0) begin errors++;
      $display("FAIL fetch_consumed got valid=%b exp 0", if_id_valid); end
    step();
    checks++; if (if_id_instr !== 16'h3456 || if_id_opcode !== 4'h3 || if_id_pc_plus1 !== 16'h0002)
    begin errors++;
      $display("FAIL fetch_i1 got i=%h op=%h pc1=%h exp 3456/3/0002",
               if_id_instr, if_id_opcode, if_id_pc_plus1); end
  endtask

  task automatic test_stall_skid();
    do_reset(1);
    step(); step();
    stall = 1'b1;
    step(); step(); step();
    checks++; if (imem_req !== 1'b0 || if_id_instr !== 16'h2123 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold got req=%b v=%b i=%h exp 0/1/2123",
                         imem_req, if_id_valid, if_id_instr); end
    step();
    checks++; if (imem_req !== 1'b0 || if_id_instr !== 16'h2123) begin errors++;
      $display("FAIL stall_hold2 got req=%b i=%h exp 0/2123", imem_req, if_id_instr); end
    stall = 1'b0;
    step();
    checks++; if (if_id_instr !== 16'h3456 || if_id_pc_plus1 !== 16'h0002 || if_id_valid !== 1'b1)
    begin errors++; $display("FAIL stall_skid_out got v=%b i=%h pc1=%h exp 1/3456/0002",
                             if_id_valid, if_id_instr, if_id_pc_plus1); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin errors++;
      $display("FAIL stall_resume got req=%b addr=%h exp 1/0002", imem_req, imem_addr); end
    step(); step();
    checks++; if (if_id_instr !== 16'h5A02 || if_id_pc_plus1 !== 16'h0003) begin errors++;
      $display("FAIL stall_next got i=%h pc1=%h exp 5A02/0003", if_id_instr, if_id_pc_plus1); end
  endtask

  task automatic test_redirect_pending();
    do_reset(3);
    redirect_valid = 1'b1; redirect_pc = 16'h0005;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0005 || imem_req !== 1'b1) begin errors++;
      $display("FAIL redir_start got req=%b addr=%h exp 1/0005", imem_req, imem_addr); end
    step();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0005 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL redir_drop got req=%b addr=%h v=%b exp 1/0005/0",
                         imem_req, imem_addr, if_id_valid); end
    step();
    checks++; if (imem_addr !== 16'h0005) begin errors++;
      $display("FAIL redir_hold_addr got %h exp 0005", imem_addr); end
    step();
    checks++; if (imem_addr !== 16'h0040 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL redir_target got req=%b addr=%h v=%b exp 1/0040/0",
                         imem_req, imem_addr, if_id_valid); end
    step();
    checks++; if (if_id_valid !== 1'b0) begin errors++;
      $display("FAIL redir_dropped got valid=%b exp 0", if_id_valid); end
    step(); step(); step();
    checks++; if (if_id_instr !== 16'h5A40 || if_id_pc_plus1 !== 16'h0041) begin errors++;
      $display("FAIL redir_new got i=%h pc1=%h exp 5A40/0041", if_id_instr, if_id_pc_plus1); end
  endtask

  task automatic test_redirect_ack_stall();
    do_reset(1);
    step(); step();
    stall = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin errors++;
      $display("FAIL flush_ifid got v=%b i=%h exp 0/0000", if_id_valid, if_id_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++;
      $display("FAIL flush_req got req=%b addr=%h exp 1/0100", imem_req, imem_addr); end
    step(); step();
    checks++; if (if_id_instr !== 16'h5B00 || if_id_pc_plus1 !== 16'h0101) begin errors++;
      $display("FAIL flush_load_stalled got i=%h pc1=%h exp 5B00/0101",
               if_id_instr, if_id_pc_plus1); end
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL flush_hold got req=%b exp 0", imem_req); end
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || imem_addr !== 16'h0200) begin errors++;
      $display("FAIL flush_skid got v=%b addr=%h exp 0/0200", if_id_valid, imem_addr); end
    step(); step();
    checks++; if (if_id_instr !== 16'h5800 || if_id_pc_plus1 !== 16'h0201) begin errors++;
      $display("FAIL flush_skid_data got i=%h pc1=%h exp 5800/0201",
               if_id_instr, if_id_pc_plus1); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    step(); step();
    checks++; if (if_id_instr !== 16'hA5FF || if_id_pc_plus1 !== 16'h0000) begin errors++;
      $display("FAIL wrap_pc1 got i=%h pc1=%h exp A5FF/0000", if_id_instr, if_id_pc_plus1); end
    checks++; if (imem_addr !== 16'h0000) begin errors++;
      $display("FAIL wrap_addr got %h exp 0000", imem_addr); end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    step(); step(); step();
    rst = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state got req=%b addr=%h v=%b exp 0/0000/0",
                         imem_req, imem_addr, if_id_valid); end
    checks++; if (if_id_instr !== 16'h0000 || if_id_pc_plus1 !== 16'h0000) begin errors++;
      $display("FAIL midrst_ifid got i=%h pc1=%h exp 0000/0000", if_id_instr, if_id_pc_plus1); end
    rst = 1'b0;
    step();
    checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL midrst_late_ack got v=%b req=%b addr=%h exp 0/1/0000",
                         if_id_valid, imem_req, imem_addr); end
    step(); step();
    checks++; if (if_id_instr !== 16'h2123 || if_id_pc_plus1 !== 16'h0001) begin errors++;
      $display("FAIL midrst_restart got i=%h pc1=%h exp 2123/0001",
               if_id_instr, if_id_pc_plus1); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall_skid();
    test_redirect_pending();
    test_redirect_ack_stall();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
